ship_cmd_scheduler: RTL and testbench

Arbitrates the player button requests (home, fire, rotate-left, rotate-right) into timed, one-cycle command strobes.
- Rotate strobes drive the spaceship angle register.
- Home strobe drives the angle clear.
- Fire uses a req/ack handshake to the bullet spawner.

The block owns all hold-qualification, auto-repeat and fire-cooldown timing, so downstream blocks act on single-cycle strobes only. It sits between the button synchronizers and the angle/bullet datapath.

---
 rtl/ship_ctrl_pkg.sv | 28 ++
 rtl/ship_hold_timer.sv | 26 ++
 rtl/ship_cmd_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ship_cmd_scheduler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ship_ctrl_pkg.sv
// Shared encodings and default timing for the ship control blocks.
package ship_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CMD_W   = 3;

    // Scheduler FSM state encoding
    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_QUALIFY   = 3'd1;
    localparam logic [STATE_W-1:0] ST_ISSUE     = 3'd2;
    localparam logic [STATE_W-1:0] ST_REPEAT    = 3'd3;
    localparam logic [STATE_W-1:0] ST_FIRE_WAIT = 3'd4;
    localparam logic [STATE_W-1:0] ST_COOLDOWN  = 3'd5;

    // Command codes, also exported on cmd_active for debug
    localparam logic [CMD_W-1:0] CMD_NONE  = 3'd0;
    localparam logic [CMD_W-1:0] CMD_HOME  = 3'd1;
    localparam logic [CMD_W-1:0] CMD_FIRE  = 3'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd4;

    // Default timing shared with the angle and bullet blocks
    localparam int unsigned DEF_HOLD_CYCLES   = 7000000;
    localparam int unsigned DEF_REPEAT_CYCLES = 7000000;
    localparam int unsigned DEF_FIRE_COOLDOWN = 12500000;
    localparam int unsigned DEF_CNT_W         = 33;

endpackage

// File: rtl/ship_hold_timer.sv
// Up-counter with synchronous clear, enable and terminal-count compare.
module ship_hold_timer #(
    parameter int unsigned CNT_W = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_done_c
);

    logic [CNT_W-1:0] r_count;

    assign o_done_c = (r_count == i_term);

    // Count toward the terminal value and hold there; clear wins over enable
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_done_c) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ship_cmd_scheduler.sv
// Turns synchronized player buttons into qualified, auto-repeating,
// single-cycle command strobes and a fire req/ack handshake.
module ship_cmd_scheduler
    import ship_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned FIRE_COOLDOWN = DEF_FIRE_COOLDOWN,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_home,
    input  logic             btn_fire,
    input  logic             btn_left,
    input  logic             btn_right,
    output logic             step_left,
    output logic             step_right,
    output logic             home,
    output logic             fire_req,
    input  logic             fire_ack,
    output logic [CMD_W-1:0] cmd_active
);

    localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_TERM   = CNT_W'(FIRE_COOLDOWN - 1);

    logic [STATE_W-1:0] r_state;
    logic [CMD_W-1:0]   r_cmd;
    logic               r_step_left;
    logic               r_step_right;
    logic               r_home;
    logic               r_fire_req;

    logic [STATE_W-1:0] w_state_nxt;
    logic [CMD_W-1:0]   w_cmd_nxt;
    logic [CMD_W-1:0]   w_req;
    logic [CNT_W-1:0]   w_term;
    logic               w_tmr_en;
    logic               w_tmr_clr;
    logic               w_tmr_done;

    // Priority decode: home > fire > rotate; opposing rotates cancel
    always_comb begin
        w_req = CMD_NONE;
        if (btn_home) begin
            w_req = CMD_HOME;
        end else if (btn_fire) begin
            w_req = CMD_FIRE;
        end else if (btn_left && !btn_right) begin
            w_req = CMD_LEFT;
        end else if (btn_right && !btn_left) begin
            w_req = CMD_RIGHT;
        end
    end

    // Next state, latched command and timer control
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_term      = '0;
        w_tmr_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req != CMD_NONE) begin
                    w_state_nxt = ST_QUALIFY;
                    w_cmd_nxt   = w_req;
                end
            end
            ST_QUALIFY: begin
                w_term   = HOLD_TERM;
                w_tmr_en = 1'b1;
                if (w_req != r_cmd) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tmr_done) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = (r_cmd == CMD_FIRE) ? ST_FIRE_WAIT : ST_REPEAT;
            end
            ST_REPEAT: begin
                // Home parks here without counting so it never repeats
                w_term   = REPEAT_TERM;
                w_tmr_en = (r_cmd != CMD_HOME);
                if (w_req != r_cmd) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cmd != CMD_HOME && w_tmr_done) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_FIRE_WAIT: begin
                if (r_fire_req && fire_ack) begin
                    w_state_nxt = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                w_term   = COOL_TERM;
                w_tmr_en = 1'b1;
                if (w_tmr_done) begin
                    w_state_nxt = (w_req == CMD_FIRE) ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_state_nxt == ST_IDLE) begin
            w_cmd_nxt = CMD_NONE;
        end
    end

    // Timer restarts from zero on every state entry
    assign w_tmr_clr = (w_state_nxt != r_state);

    ship_hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .i_term   (w_term),
        .o_done_c (w_tmr_done)
    );

    // State and latched command register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
        end
    end

    // Strobes fire on the cycle after ISSUE; fire_req holds until acknowledged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_left  <= 1'b0;
            r_step_right <= 1'b0;
            r_home       <= 1'b0;
            r_fire_req   <= 1'b0;
        end else begin
            r_step_left  <= (r_state == ST_ISSUE) && (r_cmd == CMD_LEFT);
            r_step_right <= (r_state == ST_ISSUE) && (r_cmd == CMD_RIGHT);
            r_home       <= (r_state == ST_ISSUE) && (r_cmd == CMD_HOME);
            if ((r_state == ST_ISSUE) && (r_cmd == CMD_FIRE)) begin
                r_fire_req <= 1'b1;
            end else if (r_fire_req && fire_ack) begin
                r_fire_req <= 1'b0;
            end
        end
    end

    assign step_left  = r_step_left;
    assign step_right = r_step_right;
    assign home       = r_home;
    assign fire_req   = r_fire_req;
    assign cmd_active = r_cmd;

endmodule

// File: tb/tb_ship_cmd_scheduler.sv
// Directed bench for ship_cmd_scheduler with short timing parameters.
module tb_ship_cmd_scheduler;

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_HOME  = 3'd1;
    localparam logic [2:0] C_FIRE  = 3'd2;
    localparam logic [2:0] C_LEFT  = 3'd3;
    localparam logic [2:0] C_RIGHT = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_home, btn_fire, btn_left, btn_right;
    logic       step_left, step_right, home, fire_req, fire_ack;
    logic [2:0] cmd_active;

    int n_checks = 0;
    int n_fail   = 0;

    ship_cmd_scheduler #(
        .HOLD_CYCLES   (4),
        .REPEAT_CYCLES (3),
        .FIRE_COOLDOWN (5),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_home   (btn_home),
        .btn_fire   (btn_fire),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .step_left  (step_left),
        .step_right (step_right),
        .home       (home),
        .fire_req   (fire_req),
        .fire_ack   (fire_ack),
        .cmd_active (cmd_active)
    );

    always #5 clk = ~clk;

    // Advance to the middle of the next cycle (inputs change and outputs sampled here)
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [6:0] vec(input logic l, input logic r, input logic h,
                                       input logic f, input logic [2:0] cmd);
        return {l, r, h, f, cmd};
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {step_left, step_right, home, fire_req, cmd_active};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed{L,R,H,F,cmd}=%b required=%b", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        btn_home  = 1'b0;
        btn_fire  = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        fire_ack  = 1'b0;
        step();
        step();
        chk("reset_state", 0, vec(1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        reset = 1'b0;
        step();
        chk("idle_after_reset", 0, vec(1'b0, 1'b0, 1'b0, 1'b0, C_NONE));

        // 1: right held -> strobes at 5 and 9; released during cycle 10 -> IDLE at 11
        btn_right = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            chk("s1_right_repeat", c, vec(1'b0, (c == 5 || c == 9), 1'b0, 1'b0,
                                          (c <= 10) ? C_RIGHT : C_NONE));
            if (c == 10) btn_right = 1'b0;
        end

        // 2a: left for 3 cycles only -> no strobe
        btn_left = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("s2_short_left", c, vec(1'b0, 1'b0, 1'b0, 1'b0, (c <= 2) ? C_LEFT : C_NONE));
            if (c == 2) btn_left = 1'b0;
        end

        // 2b: both rotates held -> nothing
        btn_left  = 1'b1;
        btn_right = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("s2_both_rotate", c, vec(1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        end
        btn_left  = 1'b0;
        btn_right = 1'b0;
        step();

        // 3: fire held, ack sampled at edge 7, second request after cooldown
        btn_fire = 1'b1;
        for (int c = 0; c < 22; c++) begin
            step();
            chk("s3_fire_handshake", c, vec(1'b0, 1'b0, 1'b0,
                                            ((c >= 5 && c <= 6) || (c >= 13 && c <= 14)),
                                            (c <= 19) ? C_FIRE : C_NONE));
            if (c == 6) fire_ack = 1'b1;
            if (c == 7) fire_ack = 1'b0;
            if (c == 14) begin
                fire_ack = 1'b1;
                btn_fire = 1'b0;
            end
            if (c == 15) fire_ack = 1'b0;
        end

        // 4: home held 20 cycles -> single pulse; re-press -> pulse 5 cycles later
        btn_home = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            chk("s4_home_once", c, vec(1'b0, 1'b0, (c == 5 || c == 27), 1'b0,
                                       (c <= 19 || c >= 22) ? C_HOME : C_NONE));
            if (c == 19) btn_home = 1'b0;
            if (c == 21) btn_home = 1'b1;
        end
        btn_home = 1'b0;
        step();
        chk("s4_home_release", 0, vec(1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        step();

        // 5: left repeating, fire pressed mid-REPEAT -> IDLE, no step, fire qualifies
        btn_left = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            chk("s5_preempt_fire", c, vec((c == 5), 1'b0, 1'b0, (c >= 13),
                                          (c <= 6) ? C_LEFT : ((c == 7) ? C_NONE : C_FIRE)));
            if (c == 6) btn_fire = 1'b1;
        end

        // 6: reset while fire_req pending -> everything drops, then requalify
        reset = 1'b1;
        step();
        chk("s6_reset_drop", 0, vec(1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            chk("s6_requalify", c, vec(1'b0, 1'b0, 1'b0, (c >= 5), C_FIRE));
        end
        btn_fire = 1'b0;
        btn_left = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
